// File: rtl/logic_unit_pipe_if.sv
// Handshake bundle for the pipelined bitwise logic unit.
// The slave side is the unit; the master side feeds operands and takes results.
interface logic_unit_pipe_if #(
   parameter int WIDTH = 32
);
   logic             valid_i;
   logic             ready_o;
   logic [2:0]       op_i;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] c_o;
   logic             zero_o;
   logic [15:0]      count_o;

   modport slave (
      input  valid_i, op_i, a_i, b_i, ready_i,
      output ready_o, valid_o, c_o, zero_o, count_o
   );

   modport master (
      output valid_i, op_i, a_i, b_i, ready_i,
      input  ready_o, valid_o, c_o, zero_o, count_o
   );
endinterface

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with an elastic valid/ready pipeline of STAGES registers.
// Results are computed before stage 0; later stages only delay them.
module logic_unit_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   logic_unit_pipe_if.slave bus
);

   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("logic_unit_pipe: STAGES must be in 1..4");
   end

   logic [WIDTH-1:0]              w_res;
   logic [STAGES-1:0]             w_adv;
   logic [STAGES-1:0]             r_v;
   logic [STAGES-1:0][WIDTH-1:0]  r_d;
   logic [15:0]                   r_cnt;
   logic                          w_out_xfer;

   // Combinational bitwise operation selected by op_i
   always_comb begin
      w_res = '0;
      unique case (bus.op_i)
         3'b000: w_res = bus.a_i & bus.b_i;
         3'b001: w_res = bus.a_i | bus.b_i;
         3'b010: w_res = bus.a_i ^ bus.b_i;
         3'b011: w_res = ~(bus.a_i ^ bus.b_i);
         3'b100: w_res = ~(bus.a_i & bus.b_i);
         3'b101: w_res = ~(bus.a_i | bus.b_i);
         3'b110: w_res = bus.a_i & ~bus.b_i;
         3'b111: w_res = bus.a_i;
         default: w_res = '0;
      endcase
   end

   // A stage moves unless it and every stage after it are full
   // while the output is stalled; this collapses bubbles.
   for (genvar k = 0; k < STAGES; k++) begin : g_adv
      assign w_adv[k] = !(&r_v[STAGES-1:k]) || bus.ready_i;
   end

   // Stage 0 captures a fresh result on every input transfer
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_v[0] <= 1'b0;
         r_d[0] <= '0;
      end else if (w_adv[0]) begin
         r_v[0] <= bus.valid_i;
         if (bus.valid_i) r_d[0] <= w_res;
      end
   end

   for (genvar k = 1; k < STAGES; k++) begin : g_stage
      // Later stages pull from the previous stage when they advance
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_v[k] <= 1'b0;
            r_d[k] <= '0;
         end else if (w_adv[k]) begin
            r_v[k] <= r_v[k-1];
            if (r_v[k-1]) r_d[k] <= r_d[k-1];
         end
      end
   end

   assign w_out_xfer = r_v[STAGES-1] && bus.ready_i;

   // Count completed output transfers, wrapping at 16 bits
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (w_out_xfer) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   assign bus.ready_o = w_adv[0];
   assign bus.valid_o = r_v[STAGES-1];
   assign bus.c_o     = r_d[STAGES-1];
   assign bus.zero_o  = r_v[STAGES-1] && (r_d[STAGES-1] == '0);
   assign bus.count_o = r_cnt;

endmodule
